// File: rtl/digi_pkg.sv
// Shared definitions for the digital interval source: playback states and
// default table geometry.
package digi_pkg;

  localparam int DIGI_DEPTH_DEF = 8;
  localparam int DIGI_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/digi_interval_cnt.sv
// Loadable down-counter that times one interval; tc flags the last cycle
// of the interval (count == 1).
module digi_interval_cnt
  import digi_pkg::*;
#(
  parameter int CNT_W = DIGI_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: next-state gets a default first so every path assigns it and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/digi_source_seq.sv
// Table-driven digital waveform source: plays a list of interval lengths,
// toggling dout at the end of each interval, optionally looping.
module digi_source_seq
  import digi_pkg::*;
#(
  parameter int DEPTH = DIGI_DEPTH_DEF,
  parameter int CNT_W = DIGI_CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CNT_W-1:0]         cfg_data,
  input  logic                     cfg_last,
  input  logic                     clear,
  input  logic                     init_val,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     stop,
  output logic                     dout,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic             closed_q;
  logic             dout_q;
  logic             busy_q;
  logic             done_q;
  logic [IW-1:0]    idx_q;
  logic [CNT_W-1:0] entry_q [DEPTH];

  logic             cfg_hs;
  logic             wr_en;
  logic             start_go;
  logic             tick;
  logic             is_last;
  logic             tc;
  logic [IW-1:0]    idx_nxt;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] wr_val;

  assign cfg_ready = (state_q == ST_IDLE) && !closed_q && (count_q < CW'(DEPTH));
  assign cfg_hs    = cfg_valid && cfg_ready;
  assign wr_en     = cfg_hs && !clear;

  // A zero-length interval would never expire; it is timed as one cycle.
  assign wr_val    = (cfg_data == '0) ? CNT_W'(1) : cfg_data;

  assign is_last   = (({1'b0, idx_q} + CW'(1)) == count_q);
  assign idx_nxt   = is_last ? '0 : idx_q + 1'b1;

  assign start_go  = start && !clear &&
                     (((state_q == ST_IDLE) && (count_q != '0) && !cfg_hs) ||
                      (state_q == ST_DONE));
  assign tick      = (state_q == ST_RUN) && tc && !stop && !clear;
  assign load_val  = start_go ? entry_q[0] : entry_q[idx_nxt];

  digi_interval_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (clear),
    .load     (start_go || tick),
    .en       (state_q == ST_RUN),
    .load_val (load_val),
    .tc       (tc)
  );

  // NOTE: the interval table has no reset; an entry is always written before playback can read it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_q[count_q[IW-1:0]] <= wr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      closed_q <= 1'b0;
      idx_q    <= '0;
      dout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (clear) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      closed_q <= 1'b0;
      idx_q    <= '0;
      dout_q   <= init_val;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_hs) begin
            count_q  <= count_q + 1'b1;
            closed_q <= cfg_last || ((count_q + 1'b1) == CW'(DEPTH));
          end
          if (start_go) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
            dout_q  <= init_val;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          // Stop wins over a toggle due on the same edge.
          if (stop) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (tick) begin
            dout_q <= ~dout_q;
            idx_q  <= idx_nxt;
            if (is_last && !loop_en) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (start_go) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
            dout_q  <= init_val;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;
  assign idx  = idx_q;

endmodule

// File: tb/tb_digi_source_seq.sv
// Directed bench for digi_source_seq: hand-computed waveforms for load,
// playback, loop, stop, clear and reset cases.
module tb_digi_source_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_data;
  logic        cfg_last;
  logic        clear;
  logic        init_val;
  logic        loop_en;
  logic        start;
  logic        stop;
  logic        dout;
  logic        busy;
  logic        done;
  logic [2:0]  idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digi_source_seq #(
    .DEPTH (8),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .clear     (clear),
    .init_val  (init_val),
    .loop_en   (loop_en),
    .start     (start),
    .stop      (stop),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .idx       (idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] d, input logic l);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    step();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_clear(input logic iv, input logic le);
    clear    = 1'b1;
    init_val = iv;
    loop_en  = le;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
    clear = 1'b0; init_val = 1'b0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;

    // Reset values
    step(); step();
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", idx, 0);
    check("rst_ready", cfg_ready, 1);
    rst = 1'b0;

    // Table {3,5,2}, single shot: rises at +3 edges, falls at +8, rises at +10
    load(16'd3, 1'b0);
    load(16'd5, 1'b0);
    load(16'd2, 1'b1);
    check("ready_closed", cfg_ready, 0);
    pulse_start();
    check("t2_start_busy", busy, 1);
    check("t2_start_dout", dout, 0);
    check("t2_start_idx", idx, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("t2_dout_%0d", k), dout, ((k >= 3 && k < 8) || k >= 10) ? 1 : 0);
      check($sformatf("t2_busy_%0d", k), busy, (k < 10) ? 1 : 0);
      check($sformatf("t2_done_%0d", k), done, (k >= 10) ? 1 : 0);
      if (k == 3) check("t2_idx_e1", idx, 1);
      if (k == 8) check("t2_idx_e2", idx, 2);
    end

    // Replay from DONE, then stop while entry 1 sits at count 1
    pulse_start();
    check("t3_replay_dout", dout, 0);
    check("t3_replay_idx", idx, 0);
    check("t3_replay_busy", busy, 1);
    for (int k = 1; k <= 7; k++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t3_stop_dout", dout, 1);
    check("t3_stop_done", done, 1);
    check("t3_stop_busy", busy, 0);
    check("t3_stop_idx", idx, 1);
    pulse_start();
    check("t3_again_dout", dout, 0);
    check("t3_again_idx", idx, 0);
    check("t3_again_busy", busy, 1);
    step(); step(); step();
    check("t3_again_rise", dout, 1);
    check("t3_again_idx1", idx, 1);

    // Clear, start on empty table, zero entry, start during handshake
    do_clear(1'b1, 1'b0);
    check("clr_ready", cfg_ready, 1);
    check("clr_done", done, 0);
    check("clr_busy", busy, 0);
    check("clr_dout", dout, 1);
    pulse_start();
    check("start_empty", busy, 0);
    load(16'd0, 1'b0);
    cfg_valid = 1'b1; cfg_data = 16'd2; cfg_last = 1'b1; start = 1'b1;
    step();
    cfg_valid = 1'b0; cfg_last = 1'b0; start = 1'b0;
    check("start_on_hs", busy, 0);
    check("t4_closed", cfg_ready, 0);
    pulse_start();
    check("t4_start_dout", dout, 1);
    check("t4_start_busy", busy, 1);
    step();
    check("zero_as_one_dout", dout, 0);
    check("zero_as_one_idx", idx, 1);
    step(); step();
    check("t4_end_dout", dout, 1);
    check("t4_end_done", done, 1);

    // Single entry {4} looping: square wave, half-period 4
    do_clear(1'b0, 1'b1);
    load(16'd4, 1'b1);
    pulse_start();
    for (int k = 1; k <= 17; k++) begin
      step();
      check($sformatf("sq_dout_%0d", k), dout, (k / 4) % 2);
      check($sformatf("sq_idx_%0d", k), idx, 0);
      check($sformatf("sq_busy_%0d", k), busy, 1);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("sq_stop_done", done, 1);
    check("sq_stop_busy", busy, 0);
    check("sq_stop_dout", dout, 0);

    // Fill all 8 entries without last; 9th offer refused
    do_clear(1'b0, 1'b0);
    cfg_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cfg_data = 16'(k + 1);
      if (k == 7) check("ready_before_8th", cfg_ready, 1);
      step();
    end
    check("ready_after_8th", cfg_ready, 0);
    cfg_data = 16'd9;
    step();
    check("ready_9th", cfg_ready, 0);
    cfg_valid = 1'b0;
    pulse_start();
    for (int k = 1; k <= 36; k++) begin
      step();
      check($sformatf("full_busy_%0d", k), busy, (k < 36) ? 1 : 0);
      check($sformatf("full_done_%0d", k), done, (k >= 36) ? 1 : 0);
    end
    check("full_end_dout", dout, 0);

    // Reset mid-run with clear/start/stop also high
    init_val = 1'b1;
    pulse_start();
    for (int k = 1; k <= 5; k++) step();
    check("pre_rst_idx", idx, 2);
    rst = 1'b1; clear = 1'b1; start = 1'b1; stop = 1'b1;
    step();
    check("midrst_dout", dout, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_idx", idx, 0);
    check("midrst_ready", cfg_ready, 1);
    rst = 1'b0; clear = 1'b0; stop = 1'b0;
    step();
    start = 1'b0;
    check("post_rst_start_empty", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digi_source_seq.md
DIGI_SOURCE_SEQ -- requirements
Module: digi_source_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the maximum number of interval entries (power of two, at least 2).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the interval width in clock cycles.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst, input, 1, meaning the synchronous active-high reset.
REQ-005 SHALL have port cfg_valid, input, 1, meaning an interval entry is offered.
REQ-006 SHALL have port cfg_ready, output, 1, meaning the block accepts an entry.
REQ-007 SHALL have port cfg_data, input, CNT_W, meaning the interval length in cycles.
REQ-008 SHALL have port cfg_last, input, 1, meaning the entry closes the table.
REQ-009 SHALL have port clear, input, 1, meaning empty the table and return to IDLE.
REQ-010 SHALL have port init_val, input, 1, meaning the output level at sequence start.
REQ-011 SHALL have port loop_en, input, 1, meaning restart at entry 0 after the last entry.
REQ-012 SHALL have port start, input, 1, meaning begin playback.
REQ-013 SHALL have port stop, input, 1, meaning abort playback.
REQ-014 SHALL have port dout, output, 1, meaning the digital waveform to the downstream lumped RC/Amp load.
REQ-015 SHALL have port busy, output, 1, meaning playback is active.
REQ-016 SHALL have port done, output, 1, meaning the sequence has ended or was stopped.
REQ-017 SHALL have port idx, output, clog2(DEPTH), meaning the index of the active entry.

Function
REQ-018 SHALL use exactly three states:
  - IDLE: accept loads.
  - RUN: play back.
  - DONE: hold the output.
REQ-019 SHALL drive cfg_ready=1 only in IDLE, and only while the table is not closed and count<DEPTH.
REQ-020 SHALL, on each cfg handshake, write cfg_data to entry[count] and increment count.
REQ-021 SHALL close the table when the handshake carries cfg_last=1 or count reaches DEPTH.
REQ-022 SHALL store cfg_data=0 as 1.
REQ-023 SHALL ignore start in IDLE when count=0.
REQ-024 SHALL ignore start in any cycle where a cfg handshake completes.
REQ-025 SHALL, on start sampled at edge T, enter RUN at T+1 with dout=init_val, idx=0, and the down-counter loaded with entry[0].
REQ-026 SHALL, in RUN, decrement the counter each cycle; on the cycle the counter equals 1, it SHALL toggle dout, advance idx and load entry[idx+1] at the next edge.
REQ-027 SHALL make dout edges occur exactly entry[i] cycles apart.
REQ-028 SHALL, after the last entry, wrap idx to 0 and continue when loop_en=1; otherwise it SHALL go to DONE with dout holding the final toggled value.
REQ-029 SHALL apply a 1-entry table with loop_en=1 as a square wave of half-period entry[0].
REQ-030 SHALL, on stop in RUN, go to DONE next cycle with dout frozen; stop has priority over a coincident toggle.
REQ-031 SHALL, on start in DONE, replay from entry 0 with the retained table.
REQ-032 SHALL, on clear (any state), go to IDLE with count=0, closed=0 and dout=init_val; clear has priority over start/stop.
REQ-033 SHALL drive busy=1 exactly in RUN and done=1 exactly in DONE.
REQ-034 SHALL register all outputs, with cfg_ready decoded from registered state only.

Reset
REQ-035 SHALL, on rst, set state=IDLE, count=0, closed=0, idx=0, counter=0, dout=0, busy=0, done=0, cfg_ready=1.
REQ-036 SHALL leave the table memory content undefined after reset; it is never read before being written.
REQ-037 SHALL let rst override clear, start and stop in the same cycle, including mid-playback.

Structure
REQ-038 SHALL place the state enum (IDLE/RUN/DONE) and the DEPTH/CNT_W defaults in the shared package digi_pkg.
REQ-039 SHALL use one sub-module, digi_interval_cnt, as a loadable down-counter with a terminal-count flag.
REQ-040 SHALL keep the table and FSM in digi_source_seq.

Verification
REQ-041 SHALL cover load {3,5,2} with last=1, init_val=0, loop_en=0, start -> dout rises at T+4, falls at T+9, rises at T+11, then DONE with dout=1, done=1.
REQ-042 SHALL cover load {4} with loop_en=1 -> dout toggles every 4 cycles with idx=0 throughout and busy=1.
REQ-043 SHALL cover loading 8 entries without last -> cfg_ready drops after the 8th handshake, and a 9th cfg_valid is not accepted.
REQ-044 SHALL cover entry 0 and start with count=0 -> entry behaves as 1 cycle, and start is ignored.
REQ-045 SHALL cover stop at counter=1 of entry 1 -> no toggle, DONE next cycle; start then replays from entry 0.
REQ-046 SHALL cover rst asserted mid-RUN with clear and start high -> all outputs at reset values the next cycle.
